// File: rtl/debug_pattern_generator.sv
// Synthetic colour-bar video source writing marker + RGB565 pixel words into the video FIFO.
// Each frame is one marker word (bit 16 set) followed by FRAME_WIDTH x FRAME_HEIGHT pixels in 8 vertical bars.
module debug_pattern_generator #(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272,
  parameter int LOG_LEVEL    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        queue_full,
  output logic [16:0] queue_data,
  output logic        queue_wr_en
);

  localparam int BAR_W = FRAME_WIDTH / 8;
  localparam int XW    = $clog2(FRAME_WIDTH + 1);
  localparam int YW    = $clog2(FRAME_HEIGHT + 1);
  localparam int BW    = $clog2(BAR_W + 1);

  localparam logic [XW-1:0] X_LAST   = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_HEIGHT - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  localparam logic [0:0] ST_MARKER = 1'b0;
  localparam logic [0:0] ST_PIXELS = 1'b1;

  localparam logic [16:0] MARKER_WORD = 17'h10000;

  if (FRAME_WIDTH < 8) begin : g_bad_width
    $error("FRAME_WIDTH must be at least 8");
  end
  if (FRAME_HEIGHT < 1) begin : g_bad_height
    $error("FRAME_HEIGHT must be at least 1");
  end
  if (LOG_LEVEL < 0) begin : g_bad_log
    $error("LOG_LEVEL must be non-negative");
  end

  function automatic logic [15:0] colour(input logic [2:0] b);
    case (b)
      3'd0:    colour = 16'hFFFF;
      3'd1:    colour = 16'hFFE0;
      3'd2:    colour = 16'h07FF;
      3'd3:    colour = 16'h07E0;
      3'd4:    colour = 16'hF81F;
      3'd5:    colour = 16'hF800;
      3'd6:    colour = 16'h001F;
      default: colour = 16'h0000;
    endcase
  endfunction

  // active_q goes high on the first edge after reset, loading the marker so data is 0 while in reset.
  logic          active_q, active_d;
  logic [0:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0]    bar_q, bar_d;
  logic [BW-1:0] bar_cnt_q, bar_cnt_d;
  logic [16:0]   data_q, data_d;
  logic          accept;

  assign accept      = active_q & ~queue_full;
  assign queue_wr_en = accept;
  assign queue_data  = data_q;

  always_comb begin
    active_d  = active_q;
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    bar_d     = bar_q;
    bar_cnt_d = bar_cnt_q;
    data_d    = data_q;
    if (!active_q) begin
      active_d = 1'b1;
      data_d   = MARKER_WORD;
    end else if (accept) begin
      if (state_q == ST_MARKER) begin
        state_d   = ST_PIXELS;
        x_d       = '0;
        y_d       = '0;
        bar_d     = 3'd0;
        bar_cnt_d = '0;
        data_d    = {1'b0, colour(3'd0)};
      end else if (x_q == X_LAST) begin
        x_d       = '0;
        bar_d     = 3'd0;
        bar_cnt_d = '0;
        if (y_q == Y_LAST) begin
          y_d     = '0;
          state_d = ST_MARKER;
          data_d  = MARKER_WORD;
        end else begin
          y_d    = y_q + 1'b1;
          data_d = {1'b0, colour(3'd0)};
        end
      end else begin
        x_d = x_q + 1'b1;
        // Bar advances every BAR_W columns and sticks at 7 for any remainder columns.
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_d = '0;
          bar_d     = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + 1'b1;
        end
        data_d = {1'b0, colour(bar_d)};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q  <= 1'b0;
      state_q   <= ST_MARKER;
      x_q       <= '0;
      y_q       <= '0;
      bar_q     <= 3'd0;
      bar_cnt_q <= '0;
      data_q    <= 17'h00000;
    end else begin
      active_q  <= active_d;
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bar_q     <= bar_d;
      bar_cnt_q <= bar_cnt_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_debug_pattern_generator.sv
// Directed bench: default 480x272 generator plus a 20x2 instance for remainder-column and frame-length checks.
module tb_debug_pattern_generator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        full_b = 1'b0;
  logic        full_s = 1'b1;
  logic [16:0] data_b, data_s;
  logic        wr_b, wr_s;

  int checks = 0;
  int failures = 0;
  int bi = 0;   // frame position of next expected word, big instance
  int si = 0;   // frame position of next expected word, small instance

  always #5 clk = ~clk;

  debug_pattern_generator u_big (
    .clk(clk), .reset_n(reset_n), .queue_full(full_b),
    .queue_data(data_b), .queue_wr_en(wr_b)
  );

  debug_pattern_generator #(.FRAME_WIDTH(20), .FRAME_HEIGHT(2)) u_small (
    .clk(clk), .reset_n(reset_n), .queue_full(full_s),
    .queue_data(data_s), .queue_wr_en(wr_s)
  );

  function automatic logic [16:0] exp_word(input int idx, input int w);
    int x, b;
    logic [15:0] c;
    if (idx == 0) return 17'h10000;
    x = (idx - 1) % w;
    b = x / (w / 8);
    if (b > 7) b = 7;
    case (b)
      0: c = 16'hFFFF;
      1: c = 16'hFFE0;
      2: c = 16'h07FF;
      3: c = 16'h07E0;
      4: c = 16'hF81F;
      5: c = 16'hF800;
      6: c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return {1'b0, c};
  endfunction

  // Wait (bounded) for an accepted word on the big instance with full held low.
  task automatic next_big(output logic [16:0] w, output bit ok);
    ok = 0;
    w = '0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      full_b = 1'b0;
      #1;
      if (wr_b) begin
        w = data_b;
        ok = 1;
      end
    end
  endtask

  task automatic next_small(output logic [16:0] w, output bit ok);
    ok = 0;
    w = '0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      full_s = 1'b0;
      #1;
      if (wr_s) begin
        w = data_s;
        ok = 1;
      end
    end
  endtask

  task automatic test_reset();
    logic [16:0] w;
    bit ok;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wr_b !== 1'b0) begin failures++; $display("FAIL reset_wr_en_big got=%b want=0", wr_b); end
    checks++;
    if (data_b !== 17'h00000) begin failures++; $display("FAIL reset_data_big got=%h want=00000", data_b); end
    checks++;
    if (wr_s !== 1'b0) begin failures++; $display("FAIL reset_wr_en_small got=%b want=0", wr_s); end
    checks++;
    if (data_s !== 17'h00000) begin failures++; $display("FAIL reset_data_small got=%h want=00000", data_s); end
    @(negedge clk);
    reset_n = 1'b1;
    next_big(w, ok);
    checks++;
    if (!ok || w !== 17'h10000) begin failures++; $display("FAIL first_marker ok=%0d got=%h want=10000", ok, w); end
    bi = 1;
    $display("test_reset done");
  endtask

  // Rows 0 and 1: bars of 60 words, black tail 421..480, row 1 starts white with no marker.
  task automatic test_stream();
    logic [16:0] w;
    bit ok;
    int bad = 0;
    while (bi <= 961) begin
      next_big(w, ok);
      checks++;
      if (!ok || w !== exp_word(bi, 480)) begin
        failures++;
        bad++;
        if (bad < 10) $display("FAIL stream word=%0d ok=%0d got=%h want=%h", bi, ok, w, exp_word(bi, 480));
      end
      if (bi == 481) begin
        checks++;
        if (w !== 17'h0FFFF) begin failures++; $display("FAIL row1_start got=%h want=0ffff", w); end
      end
      if (bi == 480) begin
        checks++;
        if (w !== 17'h00000) begin failures++; $display("FAIL row0_end got=%h want=00000", w); end
      end
      bi++;
    end
    $display("test_stream done words=%0d", bi);
  endtask

  task automatic test_backpressure();
    logic [16:0] w;
    logic [16:0] want;
    bit ok;
    // Stall five cycles: the pending word must be held and nothing written.
    want = exp_word(bi, 480);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      full_b = 1'b1;
      #1;
      checks++;
      if (wr_b !== 1'b0) begin failures++; $display("FAIL stall_wr_en cyc=%0d got=%b want=0", n, wr_b); end
      checks++;
      if (data_b !== want) begin failures++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", n, data_b, want); end
    end
    for (int n = 0; n < 20; n++) begin
      next_big(w, ok);
      checks++;
      if (!ok || w !== exp_word(bi, 480)) begin failures++; $display("FAIL after_stall word=%0d got=%h want=%h", bi, w, exp_word(bi, 480)); end
      bi++;
    end
    // Full toggling every cycle must not lose or repeat words.
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      full_b = n[0];
      #1;
      checks++;
      if (wr_b !== ~n[0]) begin failures++; $display("FAIL toggle_wr_en cyc=%0d got=%b want=%b", n, wr_b, ~n[0]); end
      if (!n[0]) begin
        checks++;
        if (data_b !== exp_word(bi, 480)) begin failures++; $display("FAIL toggle_data word=%0d got=%h want=%h", bi, data_b, exp_word(bi, 480)); end
        bi++;
      end
    end
    $display("test_backpressure done words=%0d", bi);
  endtask

  task automatic test_reset_mid();
    logic [16:0] w;
    bit ok;
    @(negedge clk);
    full_b = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (wr_b !== 1'b0) begin failures++; $display("FAIL midreset_wr_en got=%b want=0", wr_b); end
    checks++;
    if (data_b !== 17'h00000) begin failures++; $display("FAIL midreset_data got=%h want=00000", data_b); end
    full_s = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    next_big(w, ok);
    checks++;
    if (!ok || w !== 17'h10000) begin failures++; $display("FAIL midreset_marker ok=%0d got=%h want=10000", ok, w); end
    next_big(w, ok);
    checks++;
    if (!ok || w !== 17'h0FFFF) begin failures++; $display("FAIL midreset_first_pixel ok=%0d got=%h want=0ffff", ok, w); end
    bi = 2;
    $display("test_reset_mid done");
  endtask

  // 20x2 instance: BAR_W=2, columns 14..19 black, 41 words per frame, frames identical.
  task automatic test_small_frames();
    logic [16:0] w;
    logic [16:0] frame0 [41];
    bit ok;
    int since_marker = -1;
    int bad = 0;
    si = 0;
    for (int n = 0; n < 41 * 3; n++) begin
      next_small(w, ok);
      checks++;
      if (!ok || w !== exp_word(si, 20)) begin
        failures++;
        bad++;
        if (bad < 10) $display("FAIL small_word n=%0d ok=%0d got=%h want=%h", n, ok, w, exp_word(si, 20));
      end
      if (n < 41) frame0[n] = w;
      else begin
        checks++;
        if (w !== frame0[n % 41]) begin failures++; $display("FAIL small_repeat n=%0d got=%h want=%h", n, w, frame0[n % 41]); end
      end
      if (w[16]) begin
        if (since_marker >= 0) begin
          checks++;
          if (since_marker !== 40) begin failures++; $display("FAIL small_frame_len got=%0d want=40", since_marker); end
        end
        since_marker = 0;
      end else if (since_marker >= 0) begin
        since_marker++;
      end
      si = (si + 1) % 41;
    end
    $display("test_small_frames done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_small_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
